vrb_arb2: RTL and testbench

- Two-master to one-slave vrb arbiter that sits directly downstream of the cpu core.
- Master 0 is the core's IFU vrb port; master 1 is the core's LSU vrb port. The single slave port drives the shared memory/bus fabric.
- Conflicting commands are absorbed in per-master one-entry buffers, and the core is stalled via o_holding, which feeds the core's i_holding.
- Slave responses are returned in order and routed back to the issuing master using an outstanding-ID FIFO.

---
 rtl/vrb_arb2.sv | 183 ++++++++++++++++++
 tb/tb_vrb_arb2.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vrb_arb2.sv
// Two-master (IFU=m0, LSU=m1) to one-slave vrb arbiter with per-master skid
// buffers, a registered core stall, and an in-order response-routing ID FIFO.
module vrb_arb2 #(
  parameter int AW   = 32,
  parameter int DW   = 32,
  parameter int OSTD = 4
) (
  input  logic            clk,
  input  logic            rst_n,

  input  logic            i_m0_cmd_valid,
  input  logic [AW-1:0]   i_m0_cmd_addr,
  input  logic            i_m0_cmd_read,
  input  logic [DW-1:0]   i_m0_cmd_wdata,
  input  logic [DW/8-1:0] i_m0_cmd_wmask,
  output logic            o_m0_rsp_valid,
  output logic            o_m0_rsp_err,
  output logic [DW-1:0]   o_m0_rsp_rdata,

  input  logic            i_m1_cmd_valid,
  input  logic [AW-1:0]   i_m1_cmd_addr,
  input  logic            i_m1_cmd_read,
  input  logic [DW-1:0]   i_m1_cmd_wdata,
  input  logic [DW/8-1:0] i_m1_cmd_wmask,
  output logic            o_m1_rsp_valid,
  output logic            o_m1_rsp_err,
  output logic [DW-1:0]   o_m1_rsp_rdata,

  output logic            o_s_cmd_valid,
  output logic [AW-1:0]   o_s_cmd_addr,
  output logic            o_s_cmd_read,
  output logic [DW-1:0]   o_s_cmd_wdata,
  output logic [DW/8-1:0] o_s_cmd_wmask,
  input  logic            i_s_cmd_ready,
  input  logic            i_s_rsp_valid,
  input  logic            i_s_rsp_err,
  input  logic [DW-1:0]   i_s_rsp_rdata,

  output logic            o_holding,
  output logic            o_rsp_orphan
);

  localparam int MW = DW / 8;
  localparam int CW = $clog2(OSTD + 1);
  localparam int PW = (OSTD > 1) ? $clog2(OSTD) : 1;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          read;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } cmd_t;

  cmd_t [1:0]    live_cmd;
  cmd_t [1:0]    buf_q;
  cmd_t [1:0]    cand;
  cmd_t          win_cmd;
  logic [1:0]    live_valid;
  logic [1:0]    buf_valid_q;
  logic [1:0]    buf_valid_d;
  logic [1:0]    cand_valid;
  logic [1:0]    granted;
  logic [1:0]    capture;
  logic          win_valid;
  logic          win_id;
  logic          rr_q;          // 0: m1 wins a tie, 1: m0 wins a tie
  logic          holding_q;
  logic          orphan_q;
  logic          pop;
  logic          full;
  logic          can_issue;
  logic          s_valid;
  logic          accept;
  logic          head_id;
  logic [CW-1:0] count_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [OSTD-1:0] id_mem_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(OSTD - 1)) ? '0 : p + 1'b1;
  endfunction

  assign live_valid  = {i_m1_cmd_valid, i_m0_cmd_valid};
  assign live_cmd[0] = '{addr: i_m0_cmd_addr, read: i_m0_cmd_read,
                         wdata: i_m0_cmd_wdata, wmask: i_m0_cmd_wmask};
  assign live_cmd[1] = '{addr: i_m1_cmd_addr, read: i_m1_cmd_read,
                         wdata: i_m1_cmd_wdata, wmask: i_m1_cmd_wmask};

  // A full FIFO may still issue when a response frees a slot in the same cycle.
  assign pop       = i_s_rsp_valid & (count_q != '0);
  assign full      = (count_q == CW'(OSTD));
  assign can_issue = ~full | pop;

  // NOTE: every variable written in always_comb gets a default first so no
  // path through the block leaves it unassigned and infers a latch.
  always_comb begin
    cand_valid = buf_valid_q | live_valid;
    win_id     = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cand[i] = buf_valid_q[i] ? buf_q[i] : live_cmd[i];
    end
    unique case (cand_valid)
      2'b10:   win_id = 1'b1;
      2'b11:   win_id = ~rr_q;
      default: win_id = 1'b0;
    endcase
    win_valid = |cand_valid;
    win_cmd   = cand[win_id];
  end

  assign s_valid = win_valid & can_issue;
  assign accept  = s_valid & i_s_cmd_ready;

  // Buffered commands are held until granted; live ones are captured if not
  // taken in their arrival cycle.
  always_comb begin
    granted     = 2'b00;
    buf_valid_d = buf_valid_q;
    capture     = 2'b00;
    if (accept) granted = win_id ? 2'b10 : 2'b01;
    for (int i = 0; i < 2; i++) begin
      capture[i]     = ~buf_valid_q[i] & live_valid[i] & ~granted[i];
      buf_valid_d[i] = buf_valid_q[i] ? ~granted[i] : capture[i];
    end
  end

  // NOTE: control state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_valid_q <= 2'b00;
      holding_q   <= 1'b0;
      rr_q        <= 1'b0;
      orphan_q    <= 1'b0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      holding_q   <= |buf_valid_d;
      if (accept) begin
        rr_q     <= ~rr_q;
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (i_s_rsp_valid && count_q == '0) orphan_q <= 1'b1;
      unique case ({accept, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: payload storage has no reset; the valid bits and count guard every
  // read, so resetting it would only add reset fan-out.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (capture[i]) buf_q[i] <= live_cmd[i];
    end
    if (accept) id_mem_q[wr_ptr_q] <= win_id;
  end

  assign head_id = id_mem_q[rd_ptr_q];

  assign o_s_cmd_valid  = s_valid;
  assign o_s_cmd_addr   = s_valid ? win_cmd.addr  : '0;
  assign o_s_cmd_read   = s_valid & win_cmd.read;
  assign o_s_cmd_wdata  = s_valid ? win_cmd.wdata : '0;
  assign o_s_cmd_wmask  = s_valid ? win_cmd.wmask : '0;

  assign o_m0_rsp_valid = pop & ~head_id;
  assign o_m0_rsp_err   = o_m0_rsp_valid & i_s_rsp_err;
  assign o_m0_rsp_rdata = o_m0_rsp_valid ? i_s_rsp_rdata : '0;
  assign o_m1_rsp_valid = pop & head_id;
  assign o_m1_rsp_err   = o_m1_rsp_valid & i_s_rsp_err;
  assign o_m1_rsp_rdata = o_m1_rsp_valid ? i_s_rsp_rdata : '0;

  assign o_holding      = holding_q;
  assign o_rsp_orphan   = orphan_q;

endmodule

// File: tb/tb_vrb_arb2.sv
// Directed self-checking bench for vrb_arb2: routing, round-robin, backpressure,
// FIFO-full push-while-pop, orphan responses and mid-operation reset.
module tb_vrb_arb2;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int OSTD = 4;

  logic            clk;
  logic            rst_n;
  logic            m0_valid, m0_read, m1_valid, m1_read;
  logic [AW-1:0]   m0_addr, m1_addr;
  logic [DW-1:0]   m0_wdata, m1_wdata;
  logic [DW/8-1:0] m0_wmask, m1_wmask;
  logic            m0_rsp_valid, m0_rsp_err, m1_rsp_valid, m1_rsp_err;
  logic [DW-1:0]   m0_rsp_rdata, m1_rsp_rdata;
  logic            s_cmd_valid, s_cmd_read, s_cmd_ready;
  logic [AW-1:0]   s_cmd_addr;
  logic [DW-1:0]   s_cmd_wdata;
  logic [DW/8-1:0] s_cmd_wmask;
  logic            s_rsp_valid, s_rsp_err;
  logic [DW-1:0]   s_rsp_rdata;
  logic            holding, rsp_orphan;

  int tests = 0;
  int fails = 0;

  vrb_arb2 #(.AW(AW), .DW(DW), .OSTD(OSTD)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_m0_cmd_valid (m0_valid),
    .i_m0_cmd_addr  (m0_addr),
    .i_m0_cmd_read  (m0_read),
    .i_m0_cmd_wdata (m0_wdata),
    .i_m0_cmd_wmask (m0_wmask),
    .o_m0_rsp_valid (m0_rsp_valid),
    .o_m0_rsp_err   (m0_rsp_err),
    .o_m0_rsp_rdata (m0_rsp_rdata),
    .i_m1_cmd_valid (m1_valid),
    .i_m1_cmd_addr  (m1_addr),
    .i_m1_cmd_read  (m1_read),
    .i_m1_cmd_wdata (m1_wdata),
    .i_m1_cmd_wmask (m1_wmask),
    .o_m1_rsp_valid (m1_rsp_valid),
    .o_m1_rsp_err   (m1_rsp_err),
    .o_m1_rsp_rdata (m1_rsp_rdata),
    .o_s_cmd_valid  (s_cmd_valid),
    .o_s_cmd_addr   (s_cmd_addr),
    .o_s_cmd_read   (s_cmd_read),
    .o_s_cmd_wdata  (s_cmd_wdata),
    .o_s_cmd_wmask  (s_cmd_wmask),
    .i_s_cmd_ready  (s_cmd_ready),
    .i_s_rsp_valid  (s_rsp_valid),
    .i_s_rsp_err    (s_rsp_err),
    .i_s_rsp_rdata  (s_rsp_rdata),
    .o_holding      (holding),
    .o_rsp_orphan   (rsp_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic v, input logic [AW-1:0] a, input logic rd,
                        input logic [DW-1:0] wd, input logic [DW/8-1:0] wm);
    m0_valid = v; m0_addr = a; m0_read = rd; m0_wdata = wd; m0_wmask = wm;
  endtask

  task automatic set_m1(input logic v, input logic [AW-1:0] a, input logic rd,
                        input logic [DW-1:0] wd, input logic [DW/8-1:0] wm);
    m1_valid = v; m1_addr = a; m1_read = rd; m1_wdata = wd; m1_wmask = wm;
  endtask

  task automatic set_rsp(input logic v, input logic e, input logic [DW-1:0] d);
    s_rsp_valid = v; s_rsp_err = e; s_rsp_rdata = d;
  endtask

  task automatic idle();
    set_m0(0, '0, 0, '0, '0);
    set_m1(0, '0, 0, '0, '0);
    set_rsp(0, 0, '0);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  // Masters must stay quiet while the core is stalled.
  always @(negedge clk) begin
    if (rst_n) check("no_cmd_while_holding", holding & (m0_valid | m1_valid), 0);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    s_cmd_ready = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    check("rst_holding", holding, 0);
    check("rst_s_valid", s_cmd_valid, 0);
    check("rst_s_addr", s_cmd_addr, 0);
    check("rst_m0_rsp", m0_rsp_valid, 0);
    check("rst_m1_rsp", m1_rsp_valid, 0);
    check("rst_orphan", rsp_orphan, 0);
    rst_n = 1'b1;
    step();

    // Single master read, response two cycles later.
    set_m0(1, 'h100, 1, '0, '0);
    #1;
    check("s1_s_valid", s_cmd_valid, 1);
    check("s1_s_addr", s_cmd_addr, 'h100);
    check("s1_s_read", s_cmd_read, 1);
    check("s1_holding", holding, 0);
    step();
    idle();
    #1;
    check("s1_holding_after", holding, 0);
    check("s1_s_valid_after", s_cmd_valid, 0);
    step();
    set_rsp(1, 0, 'hDEADBEEF);
    #1;
    check("s1_m0_rsp_valid", m0_rsp_valid, 1);
    check("s1_m0_rsp_rdata", m0_rsp_rdata, 'hDEADBEEF);
    check("s1_m1_rsp_valid", m1_rsp_valid, 0);
    step();
    idle();
    #1;
    check("s1_m0_rsp_gone", m0_rsp_valid, 0);
    check("s1_orphan", rsp_orphan, 0);

    // Simultaneous requests after reset: m1 first, m0 buffered.
    do_reset();
    set_m0(1, 'h0, 1, '0, '0);
    set_m1(1, 'h2000, 0, 'h55, 'hF);
    #1;
    check("s2_s_valid", s_cmd_valid, 1);
    check("s2_s_addr_m1", s_cmd_addr, 'h2000);
    check("s2_s_read_m1", s_cmd_read, 0);
    check("s2_s_wdata_m1", s_cmd_wdata, 'h55);
    check("s2_s_wmask_m1", s_cmd_wmask, 'hF);
    check("s2_holding0", holding, 0);
    step();
    idle();
    #1;
    check("s2_holding1", holding, 1);
    check("s2_s_valid_m0", s_cmd_valid, 1);
    check("s2_s_addr_m0", s_cmd_addr, 'h0);
    check("s2_s_read_m0", s_cmd_read, 1);
    step();
    #1;
    check("s2_holding_fall", holding, 0);
    check("s2_s_valid_idle", s_cmd_valid, 0);
    set_rsp(1, 0, 'h11);
    #1;
    check("s2_rsp1_m1", m1_rsp_valid, 1);
    check("s2_rsp1_m0", m0_rsp_valid, 0);
    check("s2_rsp1_data", m1_rsp_rdata, 'h11);
    step();
    set_rsp(1, 1, 'h22);
    #1;
    check("s2_rsp2_m0", m0_rsp_valid, 1);
    check("s2_rsp2_m1", m1_rsp_valid, 0);
    check("s2_rsp2_err", m0_rsp_err, 1);
    check("s2_rsp2_data", m0_rsp_rdata, 'h22);
    step();
    idle();

    // Round-robin over four contested rounds: grants m1,m0,m1,m0,...
    for (int r = 0; r < 4; r++) begin
      set_m0(1, 32'h1000 + r, 1, '0, '0);
      set_m1(1, 32'h3000 + r, 0, 32'h100 + r, 'hF);
      #1;
      check($sformatf("rr%0d_first", r), s_cmd_addr, 32'h3000 + r);
      step();
      idle();
      #1;
      check($sformatf("rr%0d_hold", r), holding, 1);
      check($sformatf("rr%0d_second", r), s_cmd_addr, 32'h1000 + r);
      step();
      #1;
      check($sformatf("rr%0d_hold_fall", r), holding, 0);
      set_rsp(1, 0, 32'hA0 + r);
      #1;
      check($sformatf("rr%0d_rsp_m1", r), m1_rsp_valid, 1);
      step();
      set_rsp(1, 0, 32'hB0 + r);
      #1;
      check($sformatf("rr%0d_rsp_m0", r), m0_rsp_valid, 1);
      step();
      idle();
    end

    // Backpressure: m1 pending with ready low for three cycles.
    s_cmd_ready = 1'b0;
    set_m1(1, 'h4000, 0, 'hA5A5, 'h3);
    #1;
    check("bp_c0_valid", s_cmd_valid, 1);
    check("bp_c0_addr", s_cmd_addr, 'h4000);
    step();
    idle();
    for (int c = 1; c < 3; c++) begin
      #1;
      check($sformatf("bp_c%0d_valid", c), s_cmd_valid, 1);
      check($sformatf("bp_c%0d_addr", c), s_cmd_addr, 'h4000);
      check($sformatf("bp_c%0d_wdata", c), s_cmd_wdata, 'hA5A5);
      check($sformatf("bp_c%0d_hold", c), holding, 1);
      step();
    end
    s_cmd_ready = 1'b1;
    #1;
    check("bp_accept_valid", s_cmd_valid, 1);
    check("bp_accept_hold", holding, 1);
    step();
    #1;
    check("bp_after_valid", s_cmd_valid, 0);
    check("bp_after_hold", holding, 0);
    set_rsp(1, 0, 'h33);
    #1;
    check("bp_rsp_m1", m1_rsp_valid, 1);
    step();
    // Only one push happened, so this response is an orphan.
    set_rsp(1, 0, 'h44);
    #1;
    check("orph_m0", m0_rsp_valid, 0);
    check("orph_m1", m1_rsp_valid, 0);
    step();
    idle();
    #1;
    check("orph_sticky", rsp_orphan, 1);
    step();
    #1;
    check("orph_still", rsp_orphan, 1);

    do_reset();
    check("orph_cleared", rsp_orphan, 0);

    // FIFO full: ids 0,1,0,1 outstanding, fifth command waits for a slot.
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) set_m0(1, 32'h5000 + k, 1, '0, '0);
      else            set_m1(1, 32'h5000 + k, 1, '0, '0);
      #1;
      check($sformatf("full_issue%0d", k), s_cmd_valid, 1);
      step();
      idle();
    end
    set_m0(1, 'h5004, 1, '0, '0);
    #1;
    check("full_blocked", s_cmd_valid, 0);
    step();
    idle();
    #1;
    check("full_hold", holding, 1);
    check("full_still_blocked", s_cmd_valid, 0);
    step();
    set_rsp(1, 0, 'h70);
    #1;
    check("full_pp_valid", s_cmd_valid, 1);
    check("full_pp_addr", s_cmd_addr, 'h5004);
    check("full_pp_m0_rsp", m0_rsp_valid, 1);
    check("full_pp_rdata", m0_rsp_rdata, 'h70);
    step();
    idle();
    #1;
    check("full_hold_fall", holding, 0);
    for (int k = 0; k < 4; k++) begin
      set_rsp(1, 0, 32'h80 + k);
      #1;
      check($sformatf("full_drain%0d_m0", k), m0_rsp_valid, (k % 2 == 1));
      check($sformatf("full_drain%0d_m1", k), m1_rsp_valid, (k % 2 == 0));
      step();
    end
    set_rsp(1, 0, 'h90);
    #1;
    check("full_extra_m0", m0_rsp_valid, 0);
    check("full_extra_m1", m1_rsp_valid, 0);
    step();
    idle();
    #1;
    check("full_extra_orphan", rsp_orphan, 1);

    // Reset mid-operation with two outstanding and one buffered command.
    set_m0(1, 'h6000, 1, '0, '0);
    step();
    idle();
    set_m1(1, 'h6001, 1, '0, '0);
    step();
    idle();
    s_cmd_ready = 1'b0;
    set_m0(1, 'h6002, 1, '0, '0);
    step();
    idle();
    #1;
    check("mid_hold_before", holding, 1);
    rst_n = 1'b0;
    #1;
    check("mid_hold_cleared", holding, 0);
    check("mid_s_valid_cleared", s_cmd_valid, 0);
    check("mid_orphan_cleared", rsp_orphan, 0);
    step();
    rst_n = 1'b1;
    s_cmd_ready = 1'b1;
    step();
    set_rsp(1, 0, 'hC0);
    #1;
    check("mid_inflight_m0", m0_rsp_valid, 0);
    check("mid_inflight_m1", m1_rsp_valid, 0);
    step();
    idle();
    #1;
    check("mid_inflight_orphan", rsp_orphan, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
